// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cnn_pkg                                                        |
// | Purpose : Shared constants, types and helpers for the CNN datapath       |
// |           blocks (default element width, default image side length,      |
// |           element type and the frame element-count helper).             |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_VEC_SIZE   = 28;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] elem_t;

  // Number of elements in a square frame of side vec_size.
  function automatic int num_elems(input int vec_size);
    return vec_size * vec_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/col_packer_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : col_packer_bank                                                |
// | Purpose : One storage bank of the column packer. Holds one frame of      |
// |           NUM_ELEMS elements plus its full flag.                         |
// | Ports   : clk, nrst        clock / sync active-high reset (flag only)    |
// |           i_wr_en          write i_wr_data at i_wr_idx                   |
// |           i_zero_fill      with i_wr_en: zero every entry above idx      |
// |           i_set_full       mark bank full (frame committed)             |
// |           i_clr_full       mark bank empty (frame consumed)             |
// |           o_full           full flag                                     |
// |           o_mem            read-out of the whole bank                    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module col_packer_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 16,
  parameter int IDX_W      = $clog2(NUM_ELEMS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_zero_fill,
  input  logic                  i_set_full,
  input  logic                  i_clr_full,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_mem [NUM_ELEMS]
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_ELEMS];
  logic                  r_full;

  // Storage is deliberately not reset: a frame is only ever read after
  // every entry has been written (or zero-filled) by the commit cycle.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < NUM_ELEMS; k++) begin
        if (IDX_W'(k) == i_wr_idx) begin
          r_mem[k] <= i_wr_data;
        end else if (i_zero_fill && (IDX_W'(k) > i_wr_idx)) begin
          r_mem[k] <= '0;
        end
      end
    end
  end

  // Set and clear never coincide: set needs the bank empty, clear needs it full.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_full <= 1'b0;
    end else if (i_set_full) begin
      r_full <= 1'b1;
    end else if (i_clr_full) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_mem  = r_mem;

endmodule
`default_nettype wire

// File: rtl/col_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : col_packer                                                     |
// | Purpose : Packs a serial element stream into a flat column vector of     |
// |           VEC_SIZE*VEC_SIZE elements using two ping-pong banks, and      |
// |           presents each completed frame with a valid/ready handshake.    |
// | Ports   : clk, nrst               clock / sync active-high reset         |
// |           s_valid/s_ready/s_data/s_last   input element stream          |
// |           m_valid/m_ready/m_cols          output frame handshake+data   |
// |           frame_err               sticky framing-error flag             |
// |           frame_cnt, err_cnt      only with COL_PACKER_FRAME_CNT_EN     |
// | Config  : `define COL_PACKER_FRAME_CNT_EN adds frame_cnt (frames         |
// |           consumed, wrapping) and err_cnt (bad frames, saturating).     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module col_packer
  import cnn_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int VEC_SIZE   = DEFAULT_VEC_SIZE,
  localparam int NUM_ELEMS  = num_elems(VEC_SIZE)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_cols [NUM_ELEMS],
  output logic                  frame_err
`ifdef COL_PACKER_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int              IDX_W    = $clog2(NUM_ELEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_frame_err;

  logic [1:0]            w_full;
  logic [DATA_WIDTH-1:0] w_mem0 [NUM_ELEMS];
  logic [DATA_WIDTH-1:0] w_mem1 [NUM_ELEMS];

  logic w_s_ready;
  logic w_xfer;
  logic w_at_end;
  logic w_commit;
  logic w_early;
  logic w_err_ev;
  logic w_m_valid;
  logic w_take;

  assign w_s_ready = !w_full[r_wr_bank] && !nrst;
  assign w_xfer    = s_valid && w_s_ready;
  assign w_at_end  = (r_wr_idx == LAST_IDX);
  assign w_commit  = w_xfer && (w_at_end || s_last);
  assign w_early   = w_xfer && s_last && !w_at_end;
  // Error whenever s_last and the last slot disagree: early last or missing last.
  assign w_err_ev  = w_xfer && (w_at_end != s_last);
  assign w_m_valid = w_full[r_rd_bank] && !nrst;
  assign w_take    = w_m_valid && m_ready;

  col_packer_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ELEMS  (NUM_ELEMS),
    .IDX_W      (IDX_W)
  ) u_bank0 (
    .clk         (clk),
    .nrst        (nrst),
    .i_wr_en     (w_xfer && (r_wr_bank == 1'b0)),
    .i_wr_idx    (r_wr_idx),
    .i_wr_data   (s_data),
    .i_zero_fill (w_early),
    .i_set_full  (w_commit && (r_wr_bank == 1'b0)),
    .i_clr_full  (w_take && (r_rd_bank == 1'b0)),
    .o_full      (w_full[0]),
    .o_mem       (w_mem0)
  );

  col_packer_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ELEMS  (NUM_ELEMS),
    .IDX_W      (IDX_W)
  ) u_bank1 (
    .clk         (clk),
    .nrst        (nrst),
    .i_wr_en     (w_xfer && (r_wr_bank == 1'b1)),
    .i_wr_idx    (r_wr_idx),
    .i_wr_data   (s_data),
    .i_zero_fill (w_early),
    .i_set_full  (w_commit && (r_wr_bank == 1'b1)),
    .i_clr_full  (w_take && (r_rd_bank == 1'b1)),
    .o_full      (w_full[1]),
    .o_mem       (w_mem1)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (w_commit) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx  <= r_wr_idx + IDX_W'(1);
        end
      end
      if (w_err_ev) begin
        r_frame_err <= 1'b1;
      end
      if (w_take) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign s_ready   = w_s_ready;
  assign m_valid   = w_m_valid;
  assign frame_err = r_frame_err && !nrst;

  // The read bank only changes on a consume, so the vector is stable while stalled.
  always_comb begin
    for (int k = 0; k < NUM_ELEMS; k++) begin
      m_cols[k] = '0;
      if (w_m_valid) begin
        m_cols[k] = r_rd_bank ? w_mem1[k] : w_mem0[k];
      end
    end
  end

`ifdef COL_PACKER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_take) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_err_ev && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
`else
  // Frame/error counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: doc/col_packer.md
Name: col_packer

Overview:
- Stream-to-vector packer directly upstream of the column-to-image stage.
- Collects a serial pixel/column-element stream from the PE array output into a flat column vector of VEC_SIZE*VEC_SIZE elements.
- Presents each completed vector with a valid/ready handshake.
- Ping-pong (two-bank) storage lets the next frame fill while the previous one waits for the consumer.

Parameters:
DATA_WIDTH, 8, element width in bits
VEC_SIZE, 28, image side length; frame holds NUM_ELEMS = VEC_SIZE*VEC_SIZE elements

Ports:
clk  input  1  clock, all logic on rising edge
nrst  input  1  reset; synchronous, active-high
s_valid  input  1  input element valid
s_ready  output  1  block can accept an element
s_data  input  DATA_WIDTH  input element
s_last  input  1  marks final element of a frame
m_valid  output  1  completed column vector available
m_ready  input  1  consumer accepts vector
m_cols  output  NUM_ELEMS x DATA_WIDTH  unpacked array; element k = k-th accepted element of the frame
frame_err  output  1  sticky framing-error flag

Behaviour:
- Reset: nrst is synchronous, active-high.
  - While nrst=1: s_ready=0, m_valid=0, frame_err=0, m_cols=0.
  - Both bank-full flags, wr_bank, rd_bank and wr_idx are cleared to 0.
  - Storage arrays are not reset.
  - Reset mid-frame discards all partial and full frames.
- Storage: bank[0..1][0..NUM_ELEMS-1]. Per-bank full flag. wr_idx is $clog2(NUM_ELEMS) bits.
- Input handshake:
  - s_ready = !full[wr_bank] && !nrst.
  - Transfer occurs when s_valid && s_ready. s_data is written to bank[wr_bank][wr_idx].
- Frame commit: occurs when a transfer happens with wr_idx==NUM_ELEMS-1 OR s_last=1.
  - Set full[wr_bank], toggle wr_bank, set wr_idx=0.
  - Otherwise wr_idx increments.
- Early s_last (wr_idx<NUM_ELEMS-1): in the same cycle, every entry with index>wr_idx in that bank is written 0. Commit proceeds; frame_err is set.
- Missing s_last at wr_idx==NUM_ELEMS-1: commit proceeds; frame_err is set.
- frame_err is sticky until reset.
- Output:
  - m_valid = full[rd_bank].
  - m_cols = bank[rd_bank] while m_valid=1, else all-zero.
  - m_cols stays stable while m_valid && !m_ready.
  - On m_valid && m_ready: clear full[rd_bank] and toggle rd_bank.
- Latency: the last element accepted at edge T gives m_valid=1 after edge T if the read bank was empty (visible in cycle T+1).
- Simultaneous commit and consume in one cycle (different banks): both take effect.
- When both banks are full, s_ready=0. It rises the cycle after a consume.
- Throughput: one element per cycle sustained when the consumer drains a frame within NUM_ELEMS cycles.
- s_data/s_last are ignored when s_valid=0 or s_ready=0.

Optional Feature:
- Macro: COL_PACKER_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt [15:0]: number of frames consumed (m_valid&&m_ready), wrapping 0xFFFF->0. Reset value 0.
  - Adds output err_cnt [15:0]: number of committed frames with a framing error, saturating at 0xFFFF. Reset value 0.
- When undefined: neither port nor its counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds:
  - default DATA_WIDTH and VEC_SIZE constants;
  - function num_elems(vec_size);
  - typedef for the element type elem_t.
- One natural sub-module: col_packer_bank. It is a single bank with write port, zero-fill-above-index, full flag set/clear, and read-out array. col_packer instantiates it twice and adds the bank-select and handshake control.

Test Plan:
- VEC_SIZE=4, stream 0..15 back-to-back, s_last on element 15, m_ready=1 -> m_valid one cycle after the last transfer; m_cols[k]=k; frame_err=0.
- Three frames back-to-back (values 0..15, 16..31, 32..47), m_ready=0 -> s_ready drops after frame 2 commits. Pulse m_ready twice -> frames 1 and 2 delivered in order. s_ready re-rises the cycle after the first consume. Frame 3 is then accepted intact.
- s_last on element index 9 (values 100..109) -> m_cols[0..9]=100..109, m_cols[10..15]=0, frame_err=1. Next correct frame is delivered; frame_err stays 1.
- 16 elements without s_last -> frame still committed after element 15, frame_err=1. Next element starts a new frame at index 0.
- nrst=1 for one cycle after 7 elements and with one full bank -> s_ready=0, m_valid=0 during reset. A fresh 16-element frame afterwards is delivered with no stale data.
- With COL_PACKER_FRAME_CNT_EN: 5 frames consumed, 2 with an early s_last -> frame_cnt=5, err_cnt=2.
